// File: rtl/pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// pll_lock_sequencer
//
// Brings up the Gowin rPLL that clocks the PSRAM controller. The sequencer
// runs on the 27 MHz crystal clock, never on a PLL output. It pulses the PLL
// RESET pin, waits for a synchronised LOCK, and requires LOCK to hold for a
// qualification window. Only after that does it release the downstream
// reset. Timed-out attempts are retried until the retry budget is used up,
// at which point the block parks in FAIL. A lock drop while running restarts
// the whole sequence and is counted.
//
// Ports:
//   clk               27 MHz reference clock
//   resetn            asynchronous, active-low reset
//   pll_lock          raw rPLL LOCK, asynchronous to clk
//   soft_reset_req    single-cycle request to restart the PLL sequence
//   pll_reset         to rPLL RESET, active high
//   ready             PLL locked and qualified; downstream may run
//   downstream_resetn active-low reset for the PSRAM domain (mirrors ready)
//   state             0=RESET_PLL 1=WAIT_LOCK 2=STABLE 3=RUN 4=FAIL
//   retry_cnt         timed-out attempts since last resetn / soft_reset_req
//   lock_loss_cnt     saturating count of lock drops while in RUN
//   fail              high in FAIL
// ---------------------------------------------------------------------------
module pll_lock_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 2700,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pll_lock,
    input  logic       soft_reset_req,
    output logic       pll_reset,
    output logic       ready,
    output logic       downstream_resetn,
    output logic [2:0] state,
    output logic [1:0] retry_cnt,
    output logic [7:0] lock_loss_cnt,
    output logic       fail
);

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    // Terminal counts. The counter starts at zero on state entry, so the
    // last cycle of a window of N cycles is at count N-1.
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRIES);

    state_t           cur_state;
    state_t           next_state;
    logic [CNT_W-1:0] counter;
    logic             lock_meta;
    logic             lock_s;
    logic             timeout_hit;
    logic             lock_lost_run;
    logic             count_enable;
    logic [1:0]       retry_inc;

    // LOCK comes straight from the PLL and has no relation to clk, so it is
    // passed through two flops before anything looks at it. Only lock_s is
    // ever used by the sequencer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    assign retry_inc     = retry_cnt + 2'd1;
    assign lock_lost_run = (cur_state == ST_RUN) && !lock_s;
    assign count_enable  = (cur_state == ST_RESET_PLL) ||
                           (cur_state == ST_WAIT_LOCK) ||
                           (cur_state == ST_STABLE);

    // Next-state decision. A soft reset request overrides everything else.
    // In WAIT_LOCK and STABLE the lock status is checked before the counter,
    // so a lock arriving or dropping on the terminal cycle wins over the
    // timeout / qualification. Any encoding outside the five legal states
    // falls back to RESET_PLL.
    always_comb begin
        next_state  = cur_state;
        timeout_hit = 1'b0;
        if (soft_reset_req) begin
            next_state = ST_RESET_PLL;
        end else begin
            case (cur_state)
                ST_RESET_PLL: begin
                    if (counter == RST_LAST) begin
                        next_state = ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        next_state = ST_STABLE;
                    end else if (counter == TIMEOUT_LAST) begin
                        timeout_hit = 1'b1;
                        next_state  = (retry_inc == RETRY_LIMIT) ? ST_FAIL
                                                                 : ST_RESET_PLL;
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        next_state = ST_WAIT_LOCK;
                    end else if (counter == STABLE_LAST) begin
                        next_state = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        next_state = ST_RESET_PLL;
                    end
                end
                ST_FAIL: begin
                    next_state = ST_FAIL;
                end
                default: begin
                    next_state = ST_RESET_PLL;
                end
            endcase
        end
    end

    // State, counter, retry/lock-loss bookkeeping and all outputs live in one
    // register block. Outputs are decoded from next_state so they change on
    // the same edge as the state itself (ready drops with the move out of RUN,
    // pll_reset rises with the move into RESET_PLL). The counter restarts on
    // every entry, including a soft-reset re-entry of RESET_PLL, which is why
    // soft_reset_req clears it even when the state value does not change.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cur_state         <= ST_RESET_PLL;
            counter           <= '0;
            retry_cnt         <= 2'd0;
            lock_loss_cnt     <= 8'd0;
            pll_reset         <= 1'b1;
            ready             <= 1'b0;
            downstream_resetn <= 1'b0;
            fail              <= 1'b0;
        end else begin
            cur_state <= next_state;

            if (soft_reset_req || (next_state != cur_state)) begin
                counter <= '0;
            end else if (count_enable) begin
                counter <= counter + CNT_W'(1);
            end

            if (soft_reset_req) begin
                retry_cnt <= 2'd0;
            end else if (timeout_hit) begin
                retry_cnt <= retry_inc;
            end

            // Counted even when a soft reset arrives on the same cycle.
            if (lock_lost_run && (lock_loss_cnt != 8'hFF)) begin
                lock_loss_cnt <= lock_loss_cnt + 8'd1;
            end

            pll_reset         <= (next_state == ST_RESET_PLL) || (next_state == ST_FAIL);
            ready             <= (next_state == ST_RUN);
            downstream_resetn <= (next_state == ST_RUN);
            fail              <= (next_state == ST_FAIL);
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_sequencer
//
// Bench for pll_lock_sequencer with RST_CYCLES=4, LOCK_TIMEOUT=20,
// STABLE_CYCLES=8, MAX_RETRIES=2. Each scenario task drives pll_lock /
// soft_reset_req / resetn on the falling clock edge, pushes the outputs it
// expects at each following falling edge onto a queue, and then pops and
// compares them against the DUT one falling edge at a time.
// ---------------------------------------------------------------------------
module tb_pll_lock_sequencer;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRIES   = 2;

    localparam logic [2:0] S_RP   = 3'd0;
    localparam logic [2:0] S_WL   = 3'd1;
    localparam logic [2:0] S_ST   = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_FAIL = 3'd4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       pll_lock = 1'b0;
    logic       soft_reset_req = 1'b0;
    logic       pll_reset;
    logic       ready;
    logic       downstream_resetn;
    logic [2:0] state;
    logic [1:0] retry_cnt;
    logic [7:0] lock_loss_cnt;
    logic       fail;

    int checks = 0;
    int errors = 0;
    int llc_exp = 0;

    // Scoreboard: expected output vectors and their tags, in arrival order.
    logic [8:0] exp_q[$];
    string      tag_q[$];
    int         llc_q[$];

    logic [8:0] obs;
    assign obs = {state, ready, downstream_resetn, pll_reset, fail, retry_cnt};

    pll_lock_sequencer #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .MAX_RETRIES  (MAX_RETRIES),
        .CNT_W        (16)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .pll_lock         (pll_lock),
        .soft_reset_req   (soft_reset_req),
        .pll_reset        (pll_reset),
        .ready            (ready),
        .downstream_resetn(downstream_resetn),
        .state            (state),
        .retry_cnt        (retry_cnt),
        .lock_loss_cnt    (lock_loss_cnt),
        .fail             (fail)
    );

    // 100 MHz simulation clock; only the cycle count matters.
    always #5 clk = ~clk;

    // Safety net in case a scenario stalls somewhere unexpected.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Queue n identical per-cycle expectations for a given state. The other
    // outputs follow from the state: ready and downstream_resetn only in RUN,
    // pll_reset in RESET_PLL and FAIL, fail only in FAIL.
    task automatic expect_n(input string tag, input logic [2:0] st,
                            input logic [1:0] rc, input int n);
        logic on_run;
        logic rst_hi;
        logic is_fail;
        on_run  = (st == S_RUN);
        rst_hi  = (st == S_RP) || (st == S_FAIL);
        is_fail = (st == S_FAIL);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({st, on_run, on_run, rst_hi, is_fail, rc});
            tag_q.push_back(tag);
        end
    endtask

    // Reset values while resetn is held low.
    task automatic test_reset();
        resetn         = 1'b0;
        pll_lock       = 1'b0;
        soft_reset_req = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (state !== S_RP) begin errors++; $display("[TB] FAIL reset_state got %0d want 0", state); end
        checks++; if (pll_reset !== 1'b1) begin errors++; $display("[TB] FAIL reset_pll_reset got %b want 1", pll_reset); end
        checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %b want 0", ready); end
        checks++; if (downstream_resetn !== 1'b0) begin errors++; $display("[TB] FAIL reset_drstn got %b want 0", downstream_resetn); end
        checks++; if (retry_cnt !== 2'd0) begin errors++; $display("[TB] FAIL reset_retry got %0d want 0", retry_cnt); end
        checks++; if (lock_loss_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_llc got %0d want 0", lock_loss_cnt); end
        checks++; if (fail !== 1'b0) begin errors++; $display("[TB] FAIL reset_fail got %b want 0", fail); end
    endtask

    // Release reset, hold off lock for 10 cycles after pll_reset falls,
    // then qualify and reach RUN.
    task automatic test_nominal();
        logic [8:0] want;
        string      tag;
        resetn = 1'b1;
        expect_n("nominal_rst_pulse", S_RP, 2'd0, 3);
        expect_n("nominal_wait", S_WL, 2'd0, 11);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            want = exp_q.pop_front();
            tag  = tag_q.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL %s: got {st,rdy,drstn,prst,fail,retry}=%b want %b", tag, obs, want);
            end
        end
        pll_lock = 1'b1;
        expect_n("nominal_sync_latency", S_WL, 2'd0, 2);
        expect_n("nominal_stable", S_ST, 2'd0, 8);
        expect_n("nominal_run", S_RUN, 2'd0, 1);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            want = exp_q.pop_front();
            tag  = tag_q.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL %s: got {st,rdy,drstn,prst,fail,retry}=%b want %b", tag, obs, want);
            end
        end
        checks++;
        if (lock_loss_cnt !== 8'(llc_exp)) begin
            errors++;
            $display("[TB] FAIL nominal_llc got %0d want %0d", lock_loss_cnt, llc_exp);
        end
    endtask

    // From RUN: lose lock, relock, and glitch lock for one cycle while in
    // STABLE so that the synchronised drop lands at counter=5. The window
    // must restart in full and ready must stay low.
    task automatic test_glitch();
        logic [8:0] want;
        string      tag;
        pll_lock = 1'b0;
        llc_exp++;
        expect_n("glitch_run_before_drop", S_RUN, 2'd0, 2);
        expect_n("glitch_lock_lost", S_RP, 2'd0, 1);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            want = exp_q.pop_front();
            tag  = tag_q.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL %s: got {st,rdy,drstn,prst,fail,retry}=%b want %b", tag, obs, want);
            end
        end
        pll_lock = 1'b1;
        expect_n("glitch_rst_pulse", S_RP, 2'd0, 3);
        expect_n("glitch_wait", S_WL, 2'd0, 1);
        expect_n("glitch_stable_pre", S_ST, 2'd0, 4);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            want = exp_q.pop_front();
            tag  = tag_q.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL %s: got {st,rdy,drstn,prst,fail,retry}=%b want %b", tag, obs, want);
            end
        end
        pll_lock = 1'b0;
        expect_n("glitch_stable_lowraw", S_ST, 2'd0, 1);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            want = exp_q.pop_front();
            tag  = tag_q.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL %s: got {st,rdy,drstn,prst,fail,retry}=%b want %b", tag, obs, want);
            end
        end
        pll_lock = 1'b1;
        expect_n("glitch_stable_cnt5", S_ST, 2'd0, 1);
        expect_n("glitch_back_to_wait", S_WL, 2'd0, 1);
        expect_n("glitch_full_window", S_ST, 2'd0, 8);
        expect_n("glitch_run", S_RUN, 2'd0, 1);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            want = exp_q.pop_front();
            tag  = tag_q.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL %s: got {st,rdy,drstn,prst,fail,retry}=%b want %b", tag, obs, want);
            end
        end
        checks++;
        if (lock_loss_cnt !== 8'(llc_exp)) begin
            errors++;
            $display("[TB] FAIL glitch_llc got %0d want %0d", lock_loss_cnt, llc_exp);
        end
    endtask

    // From RUN: drop lock and never restore it. Two 20-cycle timeouts with a
    // 4-cycle reset pulse between them end in FAIL, which then holds.
    task automatic test_timeout();
        logic [8:0] want;
        string      tag;
        pll_lock = 1'b0;
        llc_exp++;
        expect_n("timeout_run_before_drop", S_RUN, 2'd0, 2);
        expect_n("timeout_rst1", S_RP, 2'd0, 4);
        expect_n("timeout_wait1", S_WL, 2'd0, 20);
        expect_n("timeout_retry_pulse", S_RP, 2'd1, 4);
        expect_n("timeout_wait2", S_WL, 2'd1, 20);
        expect_n("timeout_fail", S_FAIL, 2'd2, 6);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            want = exp_q.pop_front();
            tag  = tag_q.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL %s: got {st,rdy,drstn,prst,fail,retry}=%b want %b", tag, obs, want);
            end
        end
        checks++;
        if (lock_loss_cnt !== 8'(llc_exp)) begin
            errors++;
            $display("[TB] FAIL timeout_llc got %0d want %0d", lock_loss_cnt, llc_exp);
        end
    endtask

    // Soft reset out of FAIL, bring-up to RUN, then a soft reset landing on
    // the same cycle the sequencer acts on a lock drop.
    task automatic test_soft_reset();
        logic [8:0] want;
        string      tag;
        soft_reset_req = 1'b1;
        expect_n("soft_from_fail", S_RP, 2'd0, 1);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            want = exp_q.pop_front();
            tag  = tag_q.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL %s: got {st,rdy,drstn,prst,fail,retry}=%b want %b", tag, obs, want);
            end
        end
        soft_reset_req = 1'b0;
        expect_n("soft_rst_pulse", S_RP, 2'd0, 3);
        expect_n("soft_wait", S_WL, 2'd0, 1);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            want = exp_q.pop_front();
            tag  = tag_q.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL %s: got {st,rdy,drstn,prst,fail,retry}=%b want %b", tag, obs, want);
            end
        end
        pll_lock = 1'b1;
        expect_n("soft_sync_latency", S_WL, 2'd0, 2);
        expect_n("soft_stable", S_ST, 2'd0, 8);
        expect_n("soft_run", S_RUN, 2'd0, 1);
        expect_n("soft_run_hold", S_RUN, 2'd0, 2);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            want = exp_q.pop_front();
            tag  = tag_q.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL %s: got {st,rdy,drstn,prst,fail,retry}=%b want %b", tag, obs, want);
            end
        end
        // Synchronised drop reaches the FSM two edges later; the soft reset
        // is timed to coincide with that edge.
        pll_lock = 1'b0;
        expect_n("soft_coinc_run", S_RUN, 2'd0, 2);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            want = exp_q.pop_front();
            tag  = tag_q.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL %s: got {st,rdy,drstn,prst,fail,retry}=%b want %b", tag, obs, want);
            end
        end
        soft_reset_req = 1'b1;
        llc_exp++;
        expect_n("soft_coinc_rst", S_RP, 2'd0, 1);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            want = exp_q.pop_front();
            tag  = tag_q.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL %s: got {st,rdy,drstn,prst,fail,retry}=%b want %b", tag, obs, want);
            end
        end
        soft_reset_req = 1'b0;
        checks++;
        if (lock_loss_cnt !== 8'(llc_exp)) begin
            errors++;
            $display("[TB] FAIL soft_coinc_llc got %0d want %0d", lock_loss_cnt, llc_exp);
        end
        pll_lock = 1'b1;
        expect_n("soft_relock_rst", S_RP, 2'd0, 3);
        expect_n("soft_relock_wait", S_WL, 2'd0, 1);
        expect_n("soft_relock_stable", S_ST, 2'd0, 8);
        expect_n("soft_relock_run", S_RUN, 2'd0, 1);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            want = exp_q.pop_front();
            tag  = tag_q.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL %s: got {st,rdy,drstn,prst,fail,retry}=%b want %b", tag, obs, want);
            end
        end
        checks++;
        if (lock_loss_cnt !== 8'(llc_exp)) begin
            errors++;
            $display("[TB] FAIL soft_llc_once got %0d want %0d", lock_loss_cnt, llc_exp);
        end
    endtask

    // Lock loss in RUN: one cycle-exact pass, then 300 quick drop/relock
    // rounds driving lock_loss_cnt into saturation.
    task automatic test_lock_loss();
        logic [8:0] want;
        string      tag;
        int         n;
        int         llc_want;
        pll_lock = 1'b0;
        llc_exp++;
        expect_n("loss_run_before_drop", S_RUN, 2'd0, 2);
        expect_n("loss_to_reset", S_RP, 2'd0, 1);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            want = exp_q.pop_front();
            tag  = tag_q.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL %s: got {st,rdy,drstn,prst,fail,retry}=%b want %b", tag, obs, want);
            end
        end
        checks++;
        if (lock_loss_cnt !== 8'(llc_exp)) begin
            errors++;
            $display("[TB] FAIL loss_llc_first got %0d want %0d", lock_loss_cnt, llc_exp);
        end
        pll_lock = 1'b1;
        expect_n("loss_relock_rst", S_RP, 2'd0, 3);
        expect_n("loss_relock_wait", S_WL, 2'd0, 1);
        expect_n("loss_relock_stable", S_ST, 2'd0, 8);
        expect_n("loss_relock_run", S_RUN, 2'd0, 1);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            want = exp_q.pop_front();
            tag  = tag_q.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL %s: got {st,rdy,drstn,prst,fail,retry}=%b want %b", tag, obs, want);
            end
        end
        for (int it = 0; it < 300; it++) begin
            pll_lock = 1'b0;
            if (llc_exp < 255) llc_exp++;
            llc_q.push_back(llc_exp);
            n = 0;
            while ((state !== S_RP) && (n < 8)) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (state !== S_RP) begin
                errors++;
                $display("[TB] FAIL loss_loop_drop it=%0d state got %0d want 0", it, state);
            end
            pll_lock = 1'b1;
            n = 0;
            while ((state !== S_RUN) && (n < 40)) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (state !== S_RUN) begin
                errors++;
                $display("[TB] FAIL loss_loop_relock it=%0d state got %0d want 3", it, state);
            end
            llc_want = llc_q.pop_front();
            checks++;
            if (lock_loss_cnt !== 8'(llc_want)) begin
                errors++;
                $display("[TB] FAIL loss_loop_llc it=%0d got %0d want %0d", it, lock_loss_cnt, llc_want);
            end
        end
        checks++;
        if (lock_loss_cnt !== 8'd255) begin
            errors++;
            $display("[TB] FAIL loss_saturated got %0d want 255", lock_loss_cnt);
        end
        checks++;
        if (retry_cnt !== 2'd0) begin
            errors++;
            $display("[TB] FAIL loss_retry_unchanged got %0d want 0", retry_cnt);
        end
    endtask

    // Async reset while qualifying: outputs must snap to reset values between
    // clock edges, and the sequence restarts cleanly afterwards.
    task automatic test_async_reset();
        logic [8:0] want;
        string      tag;
        int         n;
        pll_lock = 1'b0;
        n = 0;
        while ((state !== S_RP) && (n < 8)) begin
            @(negedge clk);
            n++;
        end
        pll_lock = 1'b1;
        n = 0;
        while ((state !== S_ST) && (n < 20)) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (state !== S_ST) begin
            errors++;
            $display("[TB] FAIL async_reach_stable state got %0d want 2", state);
        end
        @(negedge clk);
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        checks++; if (state !== S_RP) begin errors++; $display("[TB] FAIL async_state got %0d want 0", state); end
        checks++; if (pll_reset !== 1'b1) begin errors++; $display("[TB] FAIL async_pll_reset got %b want 1", pll_reset); end
        checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL async_ready got %b want 0", ready); end
        checks++; if (downstream_resetn !== 1'b0) begin errors++; $display("[TB] FAIL async_drstn got %b want 0", downstream_resetn); end
        checks++; if (lock_loss_cnt !== 8'd0) begin errors++; $display("[TB] FAIL async_llc got %0d want 0", lock_loss_cnt); end
        checks++; if (retry_cnt !== 2'd0) begin errors++; $display("[TB] FAIL async_retry got %0d want 0", retry_cnt); end
        llc_exp = 0;
        @(negedge clk);
        resetn = 1'b1;
        expect_n("async_restart_rst", S_RP, 2'd0, 3);
        expect_n("async_restart_wait", S_WL, 2'd0, 1);
        expect_n("async_restart_stable", S_ST, 2'd0, 8);
        expect_n("async_restart_run", S_RUN, 2'd0, 1);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            want = exp_q.pop_front();
            tag  = tag_q.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL %s: got {st,rdy,drstn,prst,fail,retry}=%b want %b", tag, obs, want);
            end
        end
        checks++;
        if (lock_loss_cnt !== 8'(llc_exp)) begin
            errors++;
            $display("[TB] FAIL async_llc_after got %0d want %0d", lock_loss_cnt, llc_exp);
        end
    endtask

    // Scenario sequence; each task starts from where the previous one left
    // the DUT (mostly RUN with pll_lock high).
    initial begin
        $display("[TB] pll_lock_sequencer bench start");
        test_reset();
        test_nominal();
        test_glitch();
        test_timeout();
        test_soft_reset();
        test_lock_loss();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
